// File: rtl/spi_coef_readback.sv
`timescale 1ns/1ps
// SPI read-back slave for the modulator coefficient bank: decodes 32-bit MSB-first frames on SCLK
// and serialises a snapshotted 20-bit half-bank on MISO; MISO changes only on SCLK falling edges.
module spi_coef_readback #(
  parameter int ADDR_W  = 7,
  parameter int ENTRY_W = 5,
  parameter int FRAME_W = 32
) (
  input  logic                 SCLK,
  input  logic                 reset,
  input  logic                 cs_n,
  input  logic                 mosi,
  input  logic [8*ENTRY_W-1:0] w_cos_1,
  input  logic [8*ENTRY_W-1:0] w_sin_1,
  input  logic [8*ENTRY_W-1:0] w_cos_2,
  input  logic [8*ENTRY_W-1:0] w_sin_2,
  output logic                 miso,
  output logic                 miso_oe,
  output logic                 rd_addr_err,
  output logic                 frame_done
);

  localparam int BUS_W  = 8*ENTRY_W;
  localparam int WORD_W = 4*ENTRY_W;
  localparam int TX_W   = FRAME_W - 1 - ADDR_W;
  localparam int CNT_W  = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_CMD, S_READ, S_IGNORE, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [ADDR_W-1:0] r_cmd_sr, w_cmd_sr_nxt;
  logic [TX_W-1:0]   r_tx_sr, w_tx_sr_nxt;
  logic              r_rd_addr_err, w_rd_addr_err_nxt;
  logic [ADDR_W:0]   w_cmd;
  logic [WORD_W-1:0] w_word;
  logic              w_addr_ok;
  logic              w_in_frame;

  // Entry 4k lands in the most significant slot of the read word.
  function automatic logic [WORD_W-1:0] half_word(input logic [BUS_W-1:0] bus, input logic hi);
    logic [WORD_W-1:0] half;
    logic [WORD_W-1:0] word;
    half = hi ? bus[BUS_W-1 -: WORD_W] : bus[WORD_W-1:0];
    word = '0;
    for (int i = 0; i < 4; i++) word[(3-i)*ENTRY_W +: ENTRY_W] = half[i*ENTRY_W +: ENTRY_W];
    return word;
  endfunction

  assign w_cmd = {r_cmd_sr, mosi};

  always_comb begin
    w_word    = '0;
    w_addr_ok = 1'b1;
    case (w_cmd[ADDR_W-1:0])
      ADDR_W'(1): w_word = half_word(w_cos_1, 1'b0);
      ADDR_W'(2): w_word = half_word(w_cos_1, 1'b1);
      ADDR_W'(3): w_word = half_word(w_sin_1, 1'b0);
      ADDR_W'(4): w_word = half_word(w_sin_1, 1'b1);
      ADDR_W'(5): w_word = half_word(w_cos_2, 1'b0);
      ADDR_W'(6): w_word = half_word(w_cos_2, 1'b1);
      ADDR_W'(7): w_word = half_word(w_sin_2, 1'b0);
      ADDR_W'(8): w_word = half_word(w_sin_2, 1'b1);
      default:    w_addr_ok = 1'b0;
    endcase
  end

  assign w_in_frame = (r_state == S_CMD) || (r_state == S_READ) ||
                      (r_state == S_IGNORE) || (r_state == S_DONE);

  always_comb begin
    w_state_nxt       = r_state;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_cmd_sr_nxt      = r_cmd_sr;
    w_tx_sr_nxt       = r_tx_sr;
    w_rd_addr_err_nxt = r_rd_addr_err;
    if (w_in_frame && cs_n) begin
      // Aborted frame: drop back to idle without touching the error flag or shift data.
      w_state_nxt   = S_IDLE;
      w_bit_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_SYNC: if (cs_n) w_state_nxt = S_IDLE;
        S_IDLE: begin
          if (!cs_n) begin
            w_cmd_sr_nxt      = w_cmd[ADDR_W-1:0];
            w_bit_cnt_nxt     = CNT_W'(1);
            w_rd_addr_err_nxt = 1'b0;
            w_state_nxt       = S_CMD;
          end
        end
        S_CMD: begin
          w_cmd_sr_nxt  = w_cmd[ADDR_W-1:0];
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          if (r_bit_cnt == CMD_LAST) begin
            if (w_cmd[ADDR_W]) begin
              w_state_nxt = S_IGNORE;
            end else begin
              w_state_nxt       = S_READ;
              w_tx_sr_nxt       = {w_word, {(TX_W-WORD_W){1'b0}}};
              w_rd_addr_err_nxt = ~w_addr_ok;
            end
          end
        end
        S_READ: begin
          // Shifting on the rising edge presents the next bit to the falling-edge MISO flop.
          w_tx_sr_nxt   = {r_tx_sr[TX_W-2:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          if (r_bit_cnt == FRAME_LAST) w_state_nxt = S_DONE;
        end
        S_IGNORE: begin
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          if (r_bit_cnt == FRAME_LAST) w_state_nxt = S_DONE;
        end
        S_DONE: w_state_nxt = S_DONE;
        default: w_state_nxt = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      r_state       <= S_SYNC;
      r_bit_cnt     <= '0;
      r_cmd_sr      <= '0;
      r_tx_sr       <= '0;
      r_rd_addr_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_cmd_sr      <= w_cmd_sr_nxt;
      r_tx_sr       <= w_tx_sr_nxt;
      r_rd_addr_err <= w_rd_addr_err_nxt;
    end
  end

  always_ff @(negedge SCLK or posedge reset) begin
    if (reset) miso <= 1'b0;
    else       miso <= (r_state == S_READ) & r_tx_sr[TX_W-1];
  end

  assign miso_oe     = ~cs_n & (r_state == S_READ);
  assign frame_done  = (r_state == S_DONE);
  assign rd_addr_err = r_rd_addr_err;

endmodule

// File: tb/tb_spi_coef_readback.sv
`timescale 1ns/1ps
// Self-checking bench for spi_coef_readback: directed frame table, multi-cycle corner sequences,
// and randomised frames compared against a bank-level read-back model.
module tb_spi_coef_readback;

  logic        SCLK, reset, cs_n, mosi;
  logic [39:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;
  logic        miso, miso_oe, rd_addr_err, frame_done;

  int n_chk, n_err;
  int ent[4][8];

  typedef struct {
    logic [7:0]  cmd;
    logic [19:0] data;
    logic [23:0] exp_rx;
    logic        exp_err;
    int          exp_oe;
  } vec_t;
  vec_t tbl[8];

  spi_coef_readback dut (
    .SCLK(SCLK), .reset(reset), .cs_n(cs_n), .mosi(mosi),
    .w_cos_1(w_cos_1), .w_sin_1(w_sin_1), .w_cos_2(w_cos_2), .w_sin_2(w_sin_2),
    .miso(miso), .miso_oe(miso_oe), .rd_addr_err(rd_addr_err), .frame_done(frame_done)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply_bank();
    logic [39:0] v[4];
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++) v[b][5*i +: 5] = 5'(ent[b][i]);
    w_cos_1 = v[0]; w_sin_1 = v[1]; w_cos_2 = v[2]; w_sin_2 = v[3];
  endtask

  // Reference: bank b = (addr-1)/2, half h = (addr-1)%2, entries 4h..4h+3 packed first-entry-high.
  function automatic logic [23:0] model_rx(input logic [7:0] cmd);
    int a, b, h, word;
    a = int'(cmd[6:0]);
    if (cmd[7] || a < 1 || a > 8) return 24'h0;
    b = (a - 1) / 2;
    h = (a - 1) % 2;
    word = 0;
    for (int j = 0; j < 4; j++) word = word * 32 + ent[b][4*h + j];
    return 24'(word * 16);
  endfunction

  function automatic logic model_err(input logic [7:0] cmd);
    return !cmd[7] && (cmd[6:0] == 7'd0 || cmd[6:0] > 7'd8);
  endfunction

  task automatic run_frame(input logic [31:0] f, input int ncyc, input int chg_at,
                           input logic [39:0] chg_val, output logic [23:0] rx,
                           output int oe_cnt, output int bad, output logic done_pre,
                           output logic err_pre, output logic done_post, output logic out_post);
    rx = '0; oe_cnt = 0; bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge SCLK);
      if (i == chg_at) w_cos_1 = chg_val;
      cs_n = 1'b0;
      mosi = f[5'(31 - i)];
      #1;
      if (miso_oe) oe_cnt++;
      else if (miso) bad++;
      if (i >= 8) rx[5'(31 - i)] = miso;
    end
    @(negedge SCLK); #1;
    done_pre = frame_done;
    err_pre  = rd_addr_err;
    if (ncyc == 32) begin
      if (miso || miso_oe) bad++;
      @(negedge SCLK); #1;
      done_pre = done_pre & frame_done;
      if (miso || miso_oe) bad++;
    end
    cs_n = 1'b1; mosi = 1'b0;
    @(negedge SCLK); #1;
    done_post = frame_done;
    out_post  = miso | miso_oe;
  endtask

  initial begin
    logic [23:0] rx, exp;
    int          oe, bad;
    logic        dp, ep, dq, mq;
    logic [2:0]  acc;
    logic [31:0] sync_f;
    logic [39:0] old_cos;
    logic [7:0]  cmd;

    n_chk = 0; n_err = 0;
    reset = 1'b0; cs_n = 1'b0; mosi = 1'b0;
    for (int b = 0; b < 4; b++) for (int i = 0; i < 8; i++) ent[b][i] = 0;
    ent[0][0] = 5;  ent[0][1] = 10; ent[0][2] = 20; ent[0][3] = 30;
    ent[1][0] = 1;  ent[1][1] = 2;  ent[1][2] = 3;  ent[1][3] = 4;
    ent[3][4] = 31; ent[3][5] = 0;  ent[3][6] = 31; ent[3][7] = 0;
    apply_bank();

    tbl[0] = '{8'h03, 20'h12345, 24'h088640, 1'b0, 24};
    tbl[1] = '{8'h08, 20'hFFFFF, 24'hF83E00, 1'b0, 24};
    tbl[2] = '{8'h83, 20'hABCDE, 24'h000000, 1'b0, 0};
    tbl[3] = '{8'h00, 20'h55555, 24'h000000, 1'b1, 24};
    tbl[4] = '{8'h7F, 20'h00000, 24'h000000, 1'b1, 24};
    tbl[5] = '{8'h01, 20'h0F0F0, 24'h2AA9E0, 1'b0, 24};
    tbl[6] = '{8'h04, 20'hFFFFF, 24'h000000, 1'b0, 24};
    tbl[7] = '{8'h89, 20'h13579, 24'h000000, 1'b0, 0};

    #1 reset = 1'b1;
    #2;
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_addr_err", rd_addr_err, 0);
    chk("rst_frame_done", frame_done, 0);

    // Release reset in the middle of a frame: the stray read command must be ignored.
    @(negedge SCLK); reset = 1'b0;
    sync_f = 32'h01FFFFF0;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge SCLK);
      mosi = sync_f[5'(31 - i)];
      #1;
      acc = acc | {miso_oe, miso, frame_done};
    end
    chk("sync_hold_outputs", acc, 0);
    @(negedge SCLK); cs_n = 1'b1;

    for (int t = 0; t < 8; t++) begin
      run_frame({tbl[t].cmd, tbl[t].data, 4'h0}, 32, -1, '0, rx, oe, bad, dp, ep, dq, mq);
      chk($sformatf("tbl%0d_rx", t), rx, tbl[t].exp_rx);
      chk($sformatf("tbl%0d_oe_slots", t), oe, tbl[t].exp_oe);
      chk($sformatf("tbl%0d_addr_err", t), ep, tbl[t].exp_err);
      chk($sformatf("tbl%0d_frame_done", t), dp, 1);
      chk($sformatf("tbl%0d_miso_idle", t), bad, 0);
      chk($sformatf("tbl%0d_done_cleared", t), {dq, mq}, 0);
    end

    // Error flag survives until the next frame's first bit, then clears.
    run_frame({8'h7F, 24'h0}, 32, -1, '0, rx, oe, bad, dp, ep, dq, mq);
    chk("err_set_7f", ep, 1);
    chk("err_held_idle", rd_addr_err, 1);
    @(negedge SCLK); cs_n = 1'b0; mosi = 1'b0;
    #1 chk("err_before_bit0", rd_addr_err, 1);
    @(negedge SCLK);
    #1 chk("err_clear_bit0", rd_addr_err, 0);
    cs_n = 1'b1;
    @(negedge SCLK);

    // Bank change after command bit 7, then frame cut at clock 15.
    exp = model_rx(8'h01);
    old_cos = w_cos_1;
    run_frame({8'h01, 24'h0}, 15, 10, ~old_cos, rx, oe, bad, dp, ep, dq, mq);
    chk("midread_snapshot", rx[23:17], exp[23:17]);
    chk("midread_oe_slots", oe, 7);
    chk("cut_no_done", dp, 0);
    chk("cut_idle_done", dq, 0);
    chk("cut_idle_outputs", mq, 0);
    for (int i = 0; i < 8; i++) ent[0][i] = 31 - ent[0][i];
    apply_bank();
    run_frame({8'h01, 24'h0}, 32, -1, '0, rx, oe, bad, dp, ep, dq, mq);
    chk("after_cut_rx", rx, model_rx(8'h01));
    chk("after_cut_oe", oe, 24);
    chk("after_cut_err", ep, 0);
    chk("after_cut_done", dp, 1);

    for (int n = 0; n < 40; n++) begin
      for (int b = 0; b < 4; b++) for (int i = 0; i < 8; i++) ent[b][i] = int'($urandom_range(0, 31));
      apply_bank();
      cmd[7] = ($urandom_range(0, 3) == 0);
      cmd[6:0] = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 9));
      run_frame({cmd, 20'($urandom), 4'h0}, 32, -1, '0, rx, oe, bad, dp, ep, dq, mq);
      chk($sformatf("rnd%0d_cmd%02h_rx", n, cmd), rx, model_rx(cmd));
      chk($sformatf("rnd%0d_cmd%02h_oe", n, cmd), oe, cmd[7] ? 0 : 24);
      chk($sformatf("rnd%0d_cmd%02h_err", n, cmd), ep, model_err(cmd));
      chk($sformatf("rnd%0d_cmd%02h_done", n, cmd), dp, 1);
      chk($sformatf("rnd%0d_cmd%02h_idle", n, cmd), bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
